hams_sort_sequencer: RTL and testbench

Job-level controller for the HAMS sort pipeline. It accepts a job request (record count) from the host side and gates the record load stream into the bitonic sort stage. It then launches the bitonic and merge stages together, watches both for completion, and reports done or error. It sits above `hams_bitonic_sort_top`, the sorted-block FIFO and `hams_merge_sort_top`, and owns their `start`/`pause` inputs.

---
 rtl/hams_sort_sequencer_if.sv | 40 ++++
 rtl/hams_sort_sequencer.sv | 154 +++++++++++++++
 tb/tb_hams_sort_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hams_sort_sequencer_if.sv
// Job, load-handshake and sort-stage control signals of the HAMS sort sequencer.
// The master modport is the environment (host plus sort stages); the slave modport is the sequencer.
interface hams_sort_sequencer_if #(
    parameter int CNT_WIDTH = 11
);
    logic                 job_start;
    logic [CNT_WIDTH-1:0] job_len;
    logic                 job_abort;
    logic                 pause_req;
    logic                 job_busy;
    logic                 job_done;
    logic                 job_err;
    logic [1:0]           err_code;
    logic                 load_vld;
    logic                 load_rdy;
    logic                 bs_data_in_vld;
    logic                 bs_rdy;
    logic                 bs_start;
    logic                 bs_pause;
    logic                 bs_complete;
    logic                 fifo_empty;
    logic                 ms_start;
    logic                 ms_pause;
    logic                 ms_done;
    logic [2:0]           state_o;

    modport master (
        output job_start, job_len, job_abort, pause_req, load_vld,
               bs_rdy, bs_complete, fifo_empty, ms_done,
        input  job_busy, job_done, job_err, err_code, load_rdy,
               bs_data_in_vld, bs_start, bs_pause, ms_start, ms_pause, state_o
    );

    modport slave (
        input  job_start, job_len, job_abort, pause_req, load_vld,
               bs_rdy, bs_complete, fifo_empty, ms_done,
        output job_busy, job_done, job_err, err_code, load_rdy,
               bs_data_in_vld, bs_start, bs_pause, ms_start, ms_pause, state_o
    );
endinterface

// File: rtl/hams_sort_sequencer.sv
// Job-level controller for the HAMS sort pipeline: validates a job, gates the record
// load into the bitonic stage, launches bitonic and merge together and waits for both.
module hams_sort_sequencer #(
    parameter int NUM_ELEMENTS = 4,
    parameter int MAX_RECORDS  = 1024,
    parameter int CNT_WIDTH    = $clog2(MAX_RECORDS + 1),
    parameter int WDOG_CYCLES  = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    hams_sort_sequencer_if.slave   bus
);
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bs_seen_q, bs_seen_d;
    logic                 ms_seen_q, ms_seen_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 err_q, err_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 pause_q, pause_d;

    logic load_rdy, bs_vld, start_pulse, pause_out, done_pulse;

    function automatic logic len_bad(input logic [CNT_WIDTH-1:0] len);
        return (len == '0)
            || (32'(len) > 32'(MAX_RECORDS))
            || ((32'(len) % 32'(NUM_ELEMENTS)) != 32'd0);
    endfunction

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        bs_seen_d   = bs_seen_q;
        ms_seen_d   = ms_seen_q;
        err_code_d  = err_code_q;
        err_d       = 1'b0;
        wdog_d      = wdog_q;
        pause_d     = bus.pause_req;
        load_rdy    = 1'b0;
        bs_vld      = 1'b0;
        start_pulse = 1'b0;
        pause_out   = 1'b0;
        done_pulse  = 1'b0;

        // Abort wins over every other action and leaves all sort-stage outputs low.
        if (bus.job_abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            err_d      = 1'b1;
            err_code_d = 2'd3;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.job_start) begin
                        if (len_bad(bus.job_len)) begin
                            err_d      = 1'b1;
                            err_code_d = 2'd1;
                        end else begin
                            len_d      = bus.job_len;
                            cnt_d      = '0;
                            bs_seen_d  = 1'b0;
                            ms_seen_d  = 1'b0;
                            err_code_d = 2'd0;
                            state_d    = S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    load_rdy = bus.bs_rdy;
                    bs_vld   = bus.load_vld && bus.bs_rdy;
                    if (bs_vld) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                        if (cnt_d == len_q) state_d = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_pulse = 1'b1;
                    wdog_d      = '0;
                    state_d     = S_RUN;
                end
                S_RUN: begin
                    pause_out = pause_q;
                    bs_seen_d = bs_seen_q || bus.bs_complete;
                    ms_seen_d = ms_seen_q || bus.ms_done;
                    if (bs_seen_d && ms_seen_d) begin
                        state_d = S_FINISH;
                    end else if (!bus.fifo_empty || bus.bs_complete || bus.ms_done) begin
                        wdog_d = '0;
                    end else if (!pause_q) begin
                        if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                            state_d    = S_IDLE;
                            err_d      = 1'b1;
                            err_code_d = 2'd2;
                        end else begin
                            wdog_d = wdog_q + WD_W'(1);
                        end
                    end
                end
                S_FINISH: begin
                    done_pulse = 1'b1;
                    state_d    = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            bs_seen_q  <= 1'b0;
            ms_seen_q  <= 1'b0;
            err_code_q <= 2'd0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
            pause_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            bs_seen_q  <= bs_seen_d;
            ms_seen_q  <= ms_seen_d;
            err_code_q <= err_code_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            pause_q    <= pause_d;
        end
    end

    assign bus.job_busy       = (state_q != S_IDLE);
    assign bus.job_done       = done_pulse;
    assign bus.job_err        = err_q;
    assign bus.err_code       = err_code_q;
    assign bus.load_rdy       = load_rdy;
    assign bus.bs_data_in_vld = bs_vld;
    assign bus.bs_start       = start_pulse;
    assign bus.ms_start       = start_pulse;
    assign bus.bs_pause       = pause_out;
    assign bus.ms_pause       = pause_out;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_hams_sort_sequencer.sv
// Directed bench for hams_sort_sequencer: length checks, load gating, launch,
// completion, pause/watchdog, abort and back-to-back jobs.
module tb_hams_sort_sequencer;
    localparam int CW = 11;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   bs_start_cnt;

    hams_sort_sequencer_if #(.CNT_WIDTH(CW)) ifc ();

    hams_sort_sequencer #(
        .NUM_ELEMENTS(4),
        .MAX_RECORDS (1024),
        .CNT_WIDTH   (CW),
        .WDOG_CYCLES (50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) bs_start_cnt <= 0;
        else if (ifc.bs_start) bs_start_cnt <= bs_start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [CW-1:0] bad_lens [3];
        int vcnt;
        int done_cnt;
        int beats;
        int viol;
        int pviol;
        int n;

        total = 0;
        bad   = 0;
        bad_lens[0] = 11'd0;
        bad_lens[1] = 11'd6;
        bad_lens[2] = 11'd1028;

        rst             = 1'b1;
        ifc.job_start   = 1'b0;
        ifc.job_len     = '0;
        ifc.job_abort   = 1'b0;
        ifc.pause_req   = 1'b0;
        ifc.load_vld    = 1'b0;
        ifc.bs_rdy      = 1'b1;
        ifc.bs_complete = 1'b0;
        ifc.fifo_empty  = 1'b1;
        ifc.ms_done     = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_state", ifc.state_o, 0);
        check("rst_busy", ifc.job_busy, 0);
        check("rst_load_rdy", ifc.load_rdy, 0);
        check("rst_err", ifc.job_err, 0);
        check("rst_err_code", ifc.err_code, 0);
        check("rst_starts", {ifc.bs_start, ifc.ms_start, ifc.bs_data_in_vld}, 0);
        check("rst_pauses", {ifc.bs_pause, ifc.ms_pause, ifc.job_done}, 0);
        rst = 1'b0;

        // Job 1: length 8, back-to-back beats, completions at RUN+20 / RUN+40.
        @(negedge clk);
        ifc.job_start = 1'b1;
        ifc.job_len   = 11'd8;
        #1 check("j1_idle_rdy", ifc.load_rdy, 0);
        @(negedge clk);
        ifc.job_start = 1'b0;
        ifc.load_vld  = 1'b1;
        #1;
        check("j1_load_state", ifc.state_o, 1);
        check("j1_busy", ifc.job_busy, 1);
        check("j1_load_rdy", ifc.load_rdy, 1);
        check("j1_beat1", ifc.bs_data_in_vld, 1);
        vcnt = 0;
        repeat (7) begin
            @(negedge clk);
            #1;
            if (ifc.bs_data_in_vld) vcnt++;
            if (ifc.bs_start) vcnt += 100;
        end
        check("j1_beats", vcnt, 7);
        @(negedge clk);
        ifc.load_vld = 1'b0;
        #1;
        check("j1_launch_state", ifc.state_o, 2);
        check("j1_bs_start", ifc.bs_start, 1);
        check("j1_ms_start", ifc.ms_start, 1);
        done_cnt = 0;
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            ifc.bs_complete = (k == 20);
            ifc.ms_done     = (k == 40);
            #1;
            if (k == 0) begin
                check("j1_run_state", ifc.state_o, 3);
                check("j1_start_pulse", ifc.bs_start, 0);
            end
            if (ifc.job_done) done_cnt++;
            if (k == 41) begin
                check("j1_done_at_41", ifc.job_done, 1);
                check("j1_finish_state", ifc.state_o, 4);
            end
        end
        check("j1_done_count", done_cnt, 1);
        @(negedge clk);
        #1;
        check("j1_back_idle", ifc.state_o, 0);
        check("j1_err_code", ifc.err_code, 0);
        check("j1_no_err", ifc.job_err, 0);

        // Illegal lengths.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ifc.job_start = 1'b1;
            ifc.job_len   = bad_lens[i];
            #1 check("badlen_rdy_req", ifc.load_rdy, 0);
            @(negedge clk);
            ifc.job_start = 1'b0;
            #1;
            check("badlen_err", ifc.job_err, 1);
            check("badlen_code", ifc.err_code, 1);
            check("badlen_state", ifc.state_o, 0);
            check("badlen_rdy", ifc.load_rdy, 0);
            @(negedge clk);
            #1 check("badlen_err_pulse", ifc.job_err, 0);
        end

        // Job 2: length 16, bs_rdy toggling, random load_vld.
        @(negedge clk);
        ifc.job_start = 1'b1;
        ifc.job_len   = 11'd16;
        @(negedge clk);
        ifc.job_start = 1'b0;
        ifc.bs_rdy    = 1'b0;
        beats = 0;
        viol  = 0;
        for (int c = 0; c < 400 && ifc.state_o == 3'd1; c++) begin
            ifc.bs_rdy   = ~ifc.bs_rdy;
            ifc.load_vld = 1'($urandom_range(0, 1));
            #1;
            if (ifc.bs_data_in_vld) begin
                beats++;
                if (!ifc.bs_rdy) viol++;
            end
            @(negedge clk);
        end
        ifc.bs_rdy   = 1'b1;
        ifc.load_vld = 1'b0;
        #1;
        check("j2_beats", beats, 16);
        check("j2_no_beat_unready", viol, 0);
        check("j2_launch", ifc.state_o, 2);
        check("j2_err_code_cleared", ifc.err_code, 0);

        // Simultaneous completions, then an immediate new job.
        @(negedge clk);
        ifc.bs_complete = 1'b1;
        ifc.ms_done     = 1'b1;
        #1 check("j2_run", ifc.state_o, 3);
        @(negedge clk);
        ifc.bs_complete = 1'b0;
        ifc.ms_done     = 1'b0;
        #1;
        check("j2_done", ifc.job_done, 1);
        check("j2_finish", ifc.state_o, 4);
        @(negedge clk);
        ifc.job_start = 1'b1;
        ifc.job_len   = 11'd4;
        #1 check("j3_idle", ifc.state_o, 0);

        // Job 3: length 4, pause for 100 cycles, then watchdog timeout.
        @(negedge clk);
        ifc.job_start = 1'b0;
        ifc.load_vld  = 1'b1;
        #1 check("j3_accepted", ifc.state_o, 1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        ifc.load_vld  = 1'b0;
        ifc.pause_req = 1'b1;
        #1;
        check("j3_launch", ifc.state_o, 2);
        check("j3_no_pause_launch", ifc.bs_pause, 0);
        pviol = 0;
        for (int p = 0; p < 99; p++) begin
            @(negedge clk);
            #1;
            if (!ifc.bs_pause || !ifc.ms_pause || ifc.state_o != 3'd3) pviol++;
        end
        check("j3_paused_no_timeout", pviol, 0);
        @(negedge clk);
        ifc.pause_req = 1'b0;
        #1 check("j3_pause_lag", ifc.bs_pause, 1);
        n = -1;
        for (int n2 = 0; n2 < 80; n2++) begin
            @(negedge clk);
            #1;
            if (n2 == 0) check("j3_pause_release", ifc.ms_pause, 0);
            if (ifc.job_err) begin
                n = n2;
                break;
            end
        end
        check("j3_timeout_cycle", n, 50);
        check("j3_timeout_code", ifc.err_code, 2);
        check("j3_timeout_idle", ifc.state_o, 0);

        // Job 4: length 8, abort with the 5th beat.
        @(negedge clk);
        ifc.job_start = 1'b1;
        ifc.job_len   = 11'd8;
        @(negedge clk);
        ifc.job_start = 1'b0;
        ifc.load_vld  = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        ifc.job_abort = 1'b1;
        #1;
        check("j4_abort_state", ifc.state_o, 1);
        check("j4_abort_beat_blocked", ifc.bs_data_in_vld, 0);
        @(negedge clk);
        ifc.load_vld = 1'b0;
        #1;
        check("j4_abort_idle", ifc.state_o, 0);
        check("j4_abort_err", ifc.job_err, 1);
        check("j4_abort_code", ifc.err_code, 3);
        @(negedge clk);
        #1;
        check("j4_idle_abort_ignored", ifc.job_err, 0);
        check("j4_idle_hold", ifc.state_o, 0);
        ifc.job_abort = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("bs_start_total", bs_start_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
